multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the g23 RV32 subset core (add, or, sll, andi, lh, sh, bne). It sequences fetch, decode, execute, memory and writeback over several cycles so that the ALU and the memories see one operation per state. Both memories are reached through req/ready handshakes, so wait states are tolerated. The block drives every datapath enable and select; the PC, IR, regfile and ALU live outside it.

---
 rtl/multicycle_ctrl_pkg.sv | 53 +++++
 rtl/multicycle_ctrl_decode.sv | 34 +++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the g23 multi-cycle control unit: opcodes, funct
// fields, ALU op codes, FSM state and instruction-class encodings.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_ADD  = 3'd1,
    CLS_OR   = 3'd2,
    CLS_SLL  = 3'd3,
    CLS_ANDI = 3'd4,
    CLS_LH   = 3'd5,
    CLS_SH   = 3'd6,
    CLS_BNE  = 3'd7
  } cls_e;

  function automatic logic [3:0] alu_op_of(input cls_e c);
    case (c)
      CLS_OR:   return ALU_OR;
      CLS_SLL:  return ALU_SLL;
      CLS_ANDI: return ALU_AND;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: {opcode, funct3, funct7} -> {class, legal}.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output cls_e       cls,
  output logic       legal
);

  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  cls = CLS_ADD;
            F3_OR:   cls = CLS_OR;
            F3_SLL:  cls = CLS_SLL;
            default: cls = CLS_NONE;
          endcase
        end
      end
      OP_IMM:    if (funct3 == F3_AND)  cls = CLS_ANDI;
      OP_LOAD:   if (funct3 == F3_HALF) cls = CLS_LH;
      OP_STORE:  if (funct3 == F3_HALF) cls = CLS_SH;
      OP_BRANCH: if (funct3 == F3_BNE)  cls = CLS_BNE;
      default:   cls = CLS_NONE;
    endcase
    legal = (cls != CLS_NONE);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the g23 RV32 subset core.
// Define MULTICYCLE_CTRL_PERF_EN to build the cycle / retired-instruction counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            rs_ne,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dmem_we_half,
  output logic            dmem_re_half,
  output logic            ir_we,
  output logic            pc_we,
  output logic            pc_src,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic            reg_we,
  output logic            wb_from_mem,
  output logic            instr_retired,
  output logic            illegal,
  output logic [2:0]      state_o,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  state_e state_q, state_d;
  cls_e   cls_q, dec_cls;
  logic   dec_legal;

  ctrl_decode u_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) cls_q <= dec_cls;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (cls_q)
          CLS_LH, CLS_SH: state_d = ST_MEM;
          CLS_BNE:        state_d = ST_FETCH;
          CLS_NONE:       state_d = ST_TRAP;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM: if (dmem_ready) state_d = (cls_q == CLS_SH) ? ST_FETCH : ST_WB;
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // Outputs follow the state and latched class; everything reads 0 while rst is high
  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we_half  = 1'b0;
    dmem_re_half  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 1'b0;
    alu_op        = ALU_ADD;
    alu_src_imm   = 1'b0;
    reg_we        = 1'b0;
    wb_from_mem   = 1'b0;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    state_o       = 3'd0;
    if (!rst) begin
      state_o = state_q;
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_BNE: begin
              pc_we         = 1'b1;
              pc_src        = rs_ne;
              instr_retired = 1'b1;
            end
            CLS_LH, CLS_SH: begin
              alu_op      = ALU_ADD;
              alu_src_imm = 1'b1;
            end
            default: begin
              alu_op      = alu_op_of(cls_q);
              alu_src_imm = (cls_q == CLS_ANDI);
            end
          endcase
        end
        ST_MEM: begin
          dmem_req     = 1'b1;
          dmem_we_half = (cls_q == CLS_SH);
          dmem_re_half = (cls_q == CLS_LH);
          alu_op       = ALU_ADD;
          alu_src_imm  = 1'b1;
          if (dmem_ready && cls_q == CLS_SH) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
          end
        end
        ST_WB: begin
          reg_we        = 1'b1;
          wb_from_mem   = (cls_q == CLS_LH);
          pc_we         = 1'b1;
          instr_retired = 1'b1;
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [XLEN-1:0] cycle_q, instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + XLEN'(1);
      if (instr_retired) instret_q <= instret_q + XLEN'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table of instructions with wait states,
// expected per-instruction behaviour queued and checked at retirement/trap.
module tb_multicycle_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic            rs_ne = 1'b0;
  logic            imem_ready = 1'b0;
  logic            dmem_ready = 1'b0;
  logic            imem_req, dmem_req, dmem_we_half, dmem_re_half, ir_we, pc_we, pc_src;
  logic [3:0]      alu_op;
  logic            alu_src_imm, reg_we, wb_from_mem, instr_retired, illegal;
  logic [2:0]      state_o;
  logic [XLEN-1:0] cycle_cnt, instret_cnt;

  multicycle_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs_ne(rs_ne), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we_half(dmem_we_half),
    .dmem_re_half(dmem_re_half), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_we(reg_we),
    .wb_from_mem(wb_from_mem), .instr_retired(instr_retired), .illegal(illegal),
    .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          n_reg;
    int          n_pc;
    logic        pc_src;
    logic        wb_mem;
    logic [3:0]  alu;
    logic        imm;
    int          n_dmem;
    logic        we;
    logic        re;
    logic        trap;
    int          n_ret;
    logic [23:0] trace;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ne;
    int         iw;
    int         dw;
    exp_t       e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("outputs_in_reset",
        {29'd0, imem_req, dmem_req, ir_we, pc_we, reg_we, instr_retired, illegal, state_o},
        32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Entered shortly after a posedge; returns shortly after the posedge that ends the instruction
  task automatic run_instr(input vec_t v);
    exp_t e, o;
    int wi, wd;
    logic done, first_imem;
    opcode = v.op; funct3 = v.f3; funct7 = v.f7; rs_ne = v.ne;
    sb_q.push_back(v.e);
    o = '{60, 0, 0, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 24'd0};
    wi = 0; wd = 0; done = 1'b0; first_imem = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      imem_ready = (state_o == 3'd0) && (wi >= v.iw);
      dmem_ready = (state_o == 3'd3) && (wd >= v.dw);
      if (state_o == 3'd0) wi++;
      if (state_o == 3'd3) wd++;
      #1;
      if (c == 1) first_imem = imem_req;
      o.trace = {o.trace[20:0], state_o};
      if (reg_we) o.n_reg++;
      if (pc_we) begin o.n_pc++; o.pc_src = pc_src; end
      if (wb_from_mem) o.wb_mem = 1'b1;
      if (state_o == 3'd2) begin o.alu = alu_op; o.imm = alu_src_imm; end
      if (dmem_req && alu_src_imm && (dmem_we_half || dmem_re_half)) o.n_dmem++;
      if (dmem_we_half) o.we = 1'b1;
      if (dmem_re_half) o.re = 1'b1;
      if (instr_retired) o.n_ret++;
      if (instr_retired || illegal) begin done = 1'b1; o.lat = c; o.trap = illegal; end
      @(posedge clk);
      #1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      if (done) break;
    end
    chk("finished_in_budget", {31'd0, done}, 32'd1);
    chk("sb_not_empty", sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("imem_req_first_cycle", {31'd0, first_imem}, 32'd1);
      chk("latency", o.lat, e.lat);
      chk("state_trace", {8'd0, o.trace}, {8'd0, e.trace});
      chk("reg_we_cycles", o.n_reg, e.n_reg);
      chk("pc_we_cycles", o.n_pc, e.n_pc);
      chk("pc_src", {31'd0, o.pc_src}, {31'd0, e.pc_src});
      chk("wb_from_mem", {31'd0, o.wb_mem}, {31'd0, e.wb_mem});
      chk("exec_alu_op", {28'd0, o.alu}, {28'd0, e.alu});
      chk("exec_src_imm", {31'd0, o.imm}, {31'd0, e.imm});
      chk("dmem_cycles", o.n_dmem, e.n_dmem);
      chk("dmem_we_half", {31'd0, o.we}, {31'd0, e.we});
      chk("dmem_re_half", {31'd0, o.re}, {31'd0, e.re});
      chk("illegal", {31'd0, o.trap}, {31'd0, e.trap});
      chk("retire_pulses", o.n_ret, e.n_ret);
    end
  endtask

  initial begin
    vec_t v;
    exp_t tr;
    tr = '{3, 0, 0, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 24'o015};
    //            op          f3      f7          ne    iw dw  lat reg pc src  wbm   alu  imm   dm we    re    trap  ret trace
    vecs.push_back('{7'b0110011, 3'b000, 7'h00, 1'b0, 0, 0, '{4, 1, 1, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 24'o0124}});
    vecs.push_back('{7'b0110011, 3'b110, 7'h00, 1'b0, 2, 0, '{6, 1, 1, 1'b0, 1'b0, 4'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 24'o0124}});
    vecs.push_back('{7'b0110011, 3'b001, 7'h00, 1'b1, 0, 0, '{4, 1, 1, 1'b0, 1'b0, 4'd3, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 24'o0124}});
    vecs.push_back('{7'b0010011, 3'b111, 7'h55, 1'b0, 1, 0, '{5, 1, 1, 1'b0, 1'b0, 4'd2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1, 24'o0124}});
    vecs.push_back('{7'b0000011, 3'b001, 7'h00, 1'b0, 0, 3, '{8, 1, 1, 1'b0, 1'b1, 4'd0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1, 24'o01233334}});
    vecs.push_back('{7'b0100011, 3'b001, 7'h00, 1'b0, 0, 0, '{4, 0, 1, 1'b0, 1'b0, 4'd0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1, 24'o0123}});
    vecs.push_back('{7'b0100011, 3'b001, 7'h00, 1'b1, 0, 2, '{6, 0, 1, 1'b0, 1'b0, 4'd0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1, 24'o012333}});
    vecs.push_back('{7'b1100011, 3'b001, 7'h00, 1'b1, 0, 0, '{3, 0, 1, 1'b1, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 24'o012}});
    vecs.push_back('{7'b1100011, 3'b001, 7'h00, 1'b0, 1, 0, '{4, 0, 1, 1'b0, 1'b0, 4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 24'o012}});
    vecs.push_back('{7'b0000011, 3'b001, 7'h00, 1'b0, 0, 0, '{5, 1, 1, 1'b0, 1'b1, 4'd0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1, 24'o01234}});
    vecs.push_back('{7'b0110011, 3'b000, 7'h20, 1'b0, 0, 0, tr});
    vecs.push_back('{7'b0000011, 3'b010, 7'h00, 1'b0, 0, 0, tr});

    do_reset();
    foreach (vecs[i]) begin
      run_instr(vecs[i]);
      if (vecs[i].e.trap) do_reset();
    end

    // ecall traps and stays trapped until reset
    v = '{7'b1110011, 3'b000, 7'h00, 1'b0, 0, 0, tr};
    run_instr(v);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("trap_hold", {28'd0, illegal, state_o}, {28'd0, 1'b1, 3'd5});
      @(posedge clk);
      #1;
    end
    do_reset();
    #1;
    chk("after_trap_reset", {27'd0, illegal, imem_req, state_o}, {27'd0, 1'b0, 1'b1, 3'd0});

    // reset in the middle of a stalled sh access
    opcode = 7'b0100011; funct3 = 3'b001; funct7 = 7'h00;
    for (int c = 0; c < 10; c++) begin
      imem_ready = (state_o == 3'd0);
      dmem_ready = 1'b0;
      #1;
      if (state_o == 3'd3) break;
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b0;
    chk("mid_mem_before_rst", {29'd0, dmem_req, dmem_we_half, 1'b0} | {29'd0, state_o}, {29'd0, 3'b111});
    rst = 1'b1;
    #1;
    chk("mid_mem_rst_drop", {28'd0, dmem_req, dmem_we_half, pc_we, instr_retired}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("imem_req_after_release", {28'd0, imem_req, state_o}, {28'd0, 1'b1, 3'd0});
    run_instr(vecs[0]);

    // counters over add, sh, bne zero-wait from reset
    do_reset();
    run_instr(vecs[0]);
    run_instr(vecs[5]);
    run_instr(vecs[7]);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("instret_cnt", instret_cnt, 32'd3);
    chk("cycle_cnt", cycle_cnt, 32'd11);
`else
    chk("instret_cnt_tied", instret_cnt, 32'd0);
    chk("cycle_cnt_tied", cycle_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
